cgra_ctx_loader: RTL and testbench

- Command-driven sequencer that sits directly upstream of CGRA_Core.
- Accepts a valid/ready stream of host commands and performs the following on the core:
  - writes CTX_RC, CTX_PE and CTX_IM context memories and the LDM;
  - pulses start_in, then waits for complete_out;
  - reads back LDM words onto a response stream.
- Replaces host-side sequencing and applies the host-to-core address remapping in hardware.

---
 rtl/cgra_ctx_loader_pkg.sv | 53 +++++
 rtl/cgra_ctx_loader.sv | 253 +++++++++++++++++++++++++
 tb/tb_cgra_ctx_loader.sv | 377 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cgra_ctx_loader_pkg.sv
// Shared encodings, default widths and host-to-core address remap helpers
// for the CGRA context loader.
package cgra_ctx_loader_pkg;

  localparam int unsigned PeNumBits     = 4;
  localparam int unsigned CtxRcAddrBits = 5;
  localparam int unsigned CtxPeAddrBits = 5;
  localparam int unsigned CtxImAddrBits = 5;
  localparam int unsigned CtxRcBits     = 64;
  localparam int unsigned CtxPeBits     = 32;
  localparam int unsigned CtxImBits     = 64;
  localparam int unsigned LdmAw         = 10;
  localparam int unsigned AxiDwidthBits = 256;
  localparam int unsigned StartCycles   = 2;
  localparam int unsigned Timeout       = 65535;

  typedef enum logic [2:0] {
    OpRcWr  = 3'd0,
    OpPeWr  = 3'd1,
    OpImWr  = 3'd2,
    OpLdmWr = 3'd3,
    OpStart = 3'd4,
    OpLdmRd = 3'd5,
    OpRsv6  = 3'd6,
    OpRsv7  = 3'd7
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StRun,
    StRdIssue,
    StRdWait,
    StRdResp
  } state_e;

  // Host packs {index, pe}; the core wants {pe, index}. Result is right-aligned.
  function automatic logic [31:0] ctx_remap(input logic [31:0] addr,
                                            input int unsigned pe_bits,
                                            input int unsigned n);
    logic [31:0] pe_mask;
    logic [31:0] idx_mask;
    pe_mask  = (32'd1 << pe_bits) - 32'd1;
    idx_mask = (32'd1 << n) - 32'd1;
    return ((addr & pe_mask) << n) | ((addr >> pe_bits) & idx_mask);
  endfunction

  // Host byte address to 32-byte LDM word index; caller truncates to LDM width.
  function automatic logic [31:0] ldm_remap(input logic [31:0] addr);
    return addr >> 5;
  endfunction

endpackage

// File: rtl/cgra_ctx_loader.sv
// Command-driven sequencer in front of CGRA_Core: context/LDM writes, start/run
// handshake with timeout, and single-word LDM readback onto a response stream.
module cgra_ctx_loader
  import cgra_ctx_loader_pkg::*;
#(
  parameter int unsigned PE_NUM_BITS      = PeNumBits,
  parameter int unsigned CTX_RC_ADDR_BITS = CtxRcAddrBits,
  parameter int unsigned CTX_PE_ADDR_BITS = CtxPeAddrBits,
  parameter int unsigned CTX_IM_ADDR_BITS = CtxImAddrBits,
  parameter int unsigned CTX_RC_BITS      = CtxRcBits,
  parameter int unsigned CTX_PE_BITS      = CtxPeBits,
  parameter int unsigned CTX_IM_BITS      = CtxImBits,
  parameter int unsigned LDM_AW           = LdmAw,
  parameter int unsigned AXI_DWIDTH_BITS  = AxiDwidthBits,
  parameter int unsigned START_CYCLES     = StartCycles,
  parameter int unsigned TIMEOUT          = Timeout
) (
  input  logic                                   CLK,
  input  logic                                   RST,
  input  logic                                   cmd_valid,
  output logic                                   cmd_ready,
  input  logic [2:0]                             cmd_op,
  input  logic                                   cmd_mode,
  input  logic [31:0]                            cmd_addr,
  input  logic [AXI_DWIDTH_BITS-1:0]             cmd_data,
  output logic                                   rsp_valid,
  input  logic                                   rsp_ready,
  output logic [AXI_DWIDTH_BITS-1:0]             rsp_data,
  output logic                                   busy,
  output logic                                   error,
  output logic                                   start_out,
  output logic                                   mode_out,
  output logic [PE_NUM_BITS+CTX_RC_ADDR_BITS-1:0] ctx_rc_addr,
  output logic [CTX_RC_BITS-1:0]                 ctx_rc_din,
  output logic                                   ctx_rc_en,
  output logic                                   ctx_rc_we,
  output logic [PE_NUM_BITS+CTX_PE_ADDR_BITS-1:0] ctx_pe_addr,
  output logic [CTX_PE_BITS-1:0]                 ctx_pe_din,
  output logic                                   ctx_pe_en,
  output logic                                   ctx_pe_we,
  output logic [PE_NUM_BITS+CTX_IM_ADDR_BITS-1:0] ctx_im_addr,
  output logic [CTX_IM_BITS-1:0]                 ctx_im_din,
  output logic                                   ctx_im_en,
  output logic                                   ctx_im_we,
  output logic [LDM_AW-1:0]                      ldm_addr,
  output logic [AXI_DWIDTH_BITS-1:0]             ldm_din,
  output logic                                   ldm_en,
  output logic                                   ldm_we,
  input  logic [AXI_DWIDTH_BITS-1:0]             ldm_dout,
  input  logic                                   complete_in
);

  localparam int unsigned RcAw = PE_NUM_BITS + CTX_RC_ADDR_BITS;
  localparam int unsigned PeAw = PE_NUM_BITS + CTX_PE_ADDR_BITS;
  localparam int unsigned ImAw = PE_NUM_BITS + CTX_IM_ADDR_BITS;
  // One counter serves both the start pulse and the run timeout.
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic mode_q, mode_d;
  logic start_q, start_d;
  logic error_q, error_d;

  logic [RcAw-1:0]        rc_addr_q, rc_addr_d;
  logic [CTX_RC_BITS-1:0] rc_din_q, rc_din_d;
  logic                   rc_en_q, rc_en_d;
  logic [PeAw-1:0]        pe_addr_q, pe_addr_d;
  logic [CTX_PE_BITS-1:0] pe_din_q, pe_din_d;
  logic                   pe_en_q, pe_en_d;
  logic [ImAw-1:0]        im_addr_q, im_addr_d;
  logic [CTX_IM_BITS-1:0] im_din_q, im_din_d;
  logic                   im_en_q, im_en_d;

  logic [LDM_AW-1:0]          ldm_addr_q, ldm_addr_d;
  logic [AXI_DWIDTH_BITS-1:0] ldm_din_q, ldm_din_d;
  logic                       ldm_en_q, ldm_en_d;
  logic                       ldm_we_q, ldm_we_d;

  logic                       rsp_valid_q, rsp_valid_d;
  logic [AXI_DWIDTH_BITS-1:0] rsp_data_q, rsp_data_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    start_d     = 1'b0;
    error_d     = error_q;
    rc_addr_d   = rc_addr_q;
    rc_din_d    = rc_din_q;
    rc_en_d     = 1'b0;
    pe_addr_d   = pe_addr_q;
    pe_din_d    = pe_din_q;
    pe_en_d     = 1'b0;
    im_addr_d   = im_addr_q;
    im_din_d    = im_din_q;
    im_en_d     = 1'b0;
    ldm_addr_d  = ldm_addr_q;
    ldm_din_d   = ldm_din_q;
    ldm_en_d    = 1'b0;
    ldm_we_d    = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    cmd_ready   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          case (cmd_op_e'(cmd_op))
            OpRcWr: begin
              rc_addr_d = RcAw'(ctx_remap(cmd_addr, PE_NUM_BITS, CTX_RC_ADDR_BITS));
              rc_din_d  = CTX_RC_BITS'(cmd_data);
              rc_en_d   = 1'b1;
            end
            OpPeWr: begin
              pe_addr_d = PeAw'(ctx_remap(cmd_addr, PE_NUM_BITS, CTX_PE_ADDR_BITS));
              pe_din_d  = CTX_PE_BITS'(cmd_data);
              pe_en_d   = 1'b1;
            end
            OpImWr: begin
              im_addr_d = ImAw'(ctx_remap(cmd_addr, PE_NUM_BITS, CTX_IM_ADDR_BITS));
              im_din_d  = CTX_IM_BITS'(cmd_data);
              im_en_d   = 1'b1;
            end
            OpLdmWr: begin
              ldm_addr_d = LDM_AW'(ldm_remap(cmd_addr));
              ldm_din_d  = cmd_data;
              ldm_en_d   = 1'b1;
              ldm_we_d   = 1'b1;
            end
            OpStart: begin
              mode_d  = cmd_mode;
              start_d = 1'b1;
              cnt_d   = '0;
              state_d = StStart;
            end
            OpLdmRd: begin
              ldm_addr_d = LDM_AW'(ldm_remap(cmd_addr));
              ldm_en_d   = 1'b1;
              state_d    = StRdIssue;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      StStart: begin
        if (cnt_q == CntW'(START_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = StRun;
        end else begin
          start_d = 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // Completion takes priority over a coincident timeout.
        if (complete_in) begin
          state_d = StIdle;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRdIssue: state_d = StRdWait;
      StRdWait: begin
        rsp_data_d  = ldm_dout;
        rsp_valid_d = 1'b1;
        state_d     = StRdResp;
      end
      StRdResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      start_q     <= 1'b0;
      error_q     <= 1'b0;
      rc_addr_q   <= '0;
      rc_din_q    <= '0;
      rc_en_q     <= 1'b0;
      pe_addr_q   <= '0;
      pe_din_q    <= '0;
      pe_en_q     <= 1'b0;
      im_addr_q   <= '0;
      im_din_q    <= '0;
      im_en_q     <= 1'b0;
      ldm_addr_q  <= '0;
      ldm_din_q   <= '0;
      ldm_en_q    <= 1'b0;
      ldm_we_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      start_q     <= start_d;
      error_q     <= error_d;
      rc_addr_q   <= rc_addr_d;
      rc_din_q    <= rc_din_d;
      rc_en_q     <= rc_en_d;
      pe_addr_q   <= pe_addr_d;
      pe_din_q    <= pe_din_d;
      pe_en_q     <= pe_en_d;
      im_addr_q   <= im_addr_d;
      im_din_q    <= im_din_d;
      im_en_q     <= im_en_d;
      ldm_addr_q  <= ldm_addr_d;
      ldm_din_q   <= ldm_din_d;
      ldm_en_q    <= ldm_en_d;
      ldm_we_q    <= ldm_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign error       = error_q;
  assign start_out   = start_q;
  assign mode_out    = mode_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  // Context ports are write-only, so we tracks en.
  assign ctx_rc_addr = rc_addr_q;
  assign ctx_rc_din  = rc_din_q;
  assign ctx_rc_en   = rc_en_q;
  assign ctx_rc_we   = rc_en_q;
  assign ctx_pe_addr = pe_addr_q;
  assign ctx_pe_din  = pe_din_q;
  assign ctx_pe_en   = pe_en_q;
  assign ctx_pe_we   = pe_en_q;
  assign ctx_im_addr = im_addr_q;
  assign ctx_im_din  = im_din_q;
  assign ctx_im_en   = im_en_q;
  assign ctx_im_we   = im_en_q;
  assign ldm_addr    = ldm_addr_q;
  assign ldm_din     = ldm_din_q;
  assign ldm_en      = ldm_en_q;
  assign ldm_we      = ldm_we_q;

endmodule

// File: tb/tb_cgra_ctx_loader.sv
// Scoreboard-driven bench for cgra_ctx_loader: write remap, back-to-back writes,
// start/run, timeout, LDM readback and asynchronous reset behaviour.
module tb_cgra_ctx_loader;

  localparam int unsigned TB_TIMEOUT = 100;
  localparam int unsigned TB_START   = 2;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [2:0]   cmd_op = 3'd0;
  logic         cmd_mode = 1'b0;
  logic [31:0]  cmd_addr = 32'd0;
  logic [255:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [255:0] rsp_data;
  logic         busy, error, start_out, mode_out;
  logic [8:0]   ctx_rc_addr, ctx_pe_addr, ctx_im_addr;
  logic [63:0]  ctx_rc_din, ctx_im_din;
  logic [31:0]  ctx_pe_din;
  logic         ctx_rc_en, ctx_rc_we, ctx_pe_en, ctx_pe_we, ctx_im_en, ctx_im_we;
  logic [9:0]   ldm_addr;
  logic [255:0] ldm_din;
  logic         ldm_en, ldm_we;
  logic [255:0] ldm_dout = '0;
  logic         complete_in = 1'b0;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  typedef struct {
    logic [31:0]  addr;
    logic [255:0] data;
  } wr_t;

  wr_t          pe_sb[$];
  logic [255:0] rd_sb[$];

  cgra_ctx_loader #(
    .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_mode(cmd_mode),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .error(error), .start_out(start_out), .mode_out(mode_out),
    .ctx_rc_addr(ctx_rc_addr), .ctx_rc_din(ctx_rc_din), .ctx_rc_en(ctx_rc_en),
    .ctx_rc_we(ctx_rc_we),
    .ctx_pe_addr(ctx_pe_addr), .ctx_pe_din(ctx_pe_din), .ctx_pe_en(ctx_pe_en),
    .ctx_pe_we(ctx_pe_we),
    .ctx_im_addr(ctx_im_addr), .ctx_im_din(ctx_im_din), .ctx_im_en(ctx_im_en),
    .ctx_im_we(ctx_im_we),
    .ldm_addr(ldm_addr), .ldm_din(ldm_din), .ldm_en(ldm_en), .ldm_we(ldm_we),
    .ldm_dout(ldm_dout), .complete_in(complete_in)
  );

  always #5 CLK = ~CLK;

  function automatic logic [255:0] ldm_pattern(input logic [9:0] a);
    return {32{8'hA5}} ^ {246'd0, a};
  endfunction

  // LDM model: registered read, one cycle after en.
  always @(posedge CLK) begin
    if (ldm_en && !ldm_we) ldm_dout <= ldm_pattern(ldm_addr);
  end

  task automatic test_reset();
    #1;
    n_total++;
    if ({busy, error, start_out, mode_out, rsp_valid} !== 5'b0) begin
      $display("FAIL reset_status: got %b expected 00000",
               {busy, error, start_out, mode_out, rsp_valid});
    end else n_pass++;
    n_total++;
    if ({ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, ldm_we} !== 5'b0) begin
      $display("FAIL reset_enables: got %b expected 00000",
               {ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, ldm_we});
    end else n_pass++;
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cmd_ready);
    else n_pass++;
  endtask

  task automatic test_write_remap();
    logic [255:0] d;
    // RC write: upper payload bits must be dropped.
    d = {{6{32'hCAFE_F00D}}, 64'hDEAD_BEEF_0123_4567};
    @(negedge CLK);
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_addr = 32'h0000_0013; cmd_data = d;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if ({ctx_rc_en, ctx_rc_we} !== 2'b11) $display("FAIL rc_en_we: got %b expected 11",
                                                   {ctx_rc_en, ctx_rc_we});
    else n_pass++;
    n_total++;
    if (ctx_rc_addr !== {4'h3, 5'h01}) $display("FAIL rc_addr: got %h expected %h",
                                                ctx_rc_addr, {4'h3, 5'h01});
    else n_pass++;
    n_total++;
    if (ctx_rc_din !== 64'hDEAD_BEEF_0123_4567)
      $display("FAIL rc_din: got %h expected deadbeef01234567", ctx_rc_din);
    else n_pass++;
    n_total++;
    if ({ctx_pe_en, ctx_im_en, ldm_en} !== 3'b0)
      $display("FAIL rc_others_idle: got %b expected 000", {ctx_pe_en, ctx_im_en, ldm_en});
    else n_pass++;
    @(negedge CLK);
    n_total++;
    if (ctx_rc_en !== 1'b0) $display("FAIL rc_single_pulse: got %b expected 0", ctx_rc_en);
    else n_pass++;

    // LDM writes at two addresses exercising the [14:5] slice.
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'h0100_8000 : 32'h0000_7FE0;
      d = {$urandom(), $urandom(), $urandom(), $urandom(),
           $urandom(), $urandom(), $urandom(), $urandom()};
      cmd_valid = 1'b1; cmd_op = 3'd3; cmd_addr = a; cmd_data = d;
      @(negedge CLK);
      cmd_valid = 1'b0;
      n_total++;
      if ({ldm_en, ldm_we} !== 2'b11) $display("FAIL ldm_wr_en: got %b expected 11",
                                               {ldm_en, ldm_we});
      else n_pass++;
      n_total++;
      if (ldm_addr !== a[14:5]) $display("FAIL ldm_wr_addr: got %h expected %h",
                                         ldm_addr, a[14:5]);
      else n_pass++;
      n_total++;
      if (ldm_din !== d) $display("FAIL ldm_wr_din: got %h expected %h", ldm_din, d);
      else n_pass++;
      @(negedge CLK);
      n_total++;
      if ({ldm_en, ldm_we} !== 2'b00) $display("FAIL ldm_wr_pulse: got %b expected 00",
                                               {ldm_en, ldm_we});
      else n_pass++;
    end
  endtask

  task automatic test_im_write();
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 32'h0000_01F5;
    cmd_data = {192'd0, 64'h0F1E_2D3C_4B5A_6978};
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if ({ctx_im_en, ctx_im_we, ctx_rc_en, ctx_pe_en, ldm_en} !== 5'b11000)
      $display("FAIL im_enables: got %b expected 11000",
               {ctx_im_en, ctx_im_we, ctx_rc_en, ctx_pe_en, ldm_en});
    else n_pass++;
    n_total++;
    if (ctx_im_addr !== {4'h5, 5'h1F}) $display("FAIL im_addr: got %h expected %h",
                                                ctx_im_addr, {4'h5, 5'h1F});
    else n_pass++;
    n_total++;
    if (ctx_im_din !== 64'h0F1E_2D3C_4B5A_6978)
      $display("FAIL im_din: got %h expected 0f1e2d3c4b5a6978", ctx_im_din);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    wr_t e;
    logic [8:0] ea;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        e  = pe_sb.pop_front();
        ea = {e.addr[3:0], e.addr[8:4]};
        n_total++;
        if ({ctx_pe_en, ctx_pe_we} !== 2'b11) $display("FAIL b2b_pe_en[%0d]: got %b expected 11",
                                                       i - 1, {ctx_pe_en, ctx_pe_we});
        else n_pass++;
        n_total++;
        if (ctx_pe_addr !== ea) $display("FAIL b2b_pe_addr[%0d]: got %h expected %h",
                                         i - 1, ctx_pe_addr, ea);
        else n_pass++;
        n_total++;
        if (ctx_pe_din !== e.data[31:0]) $display("FAIL b2b_pe_din[%0d]: got %h expected %h",
                                                  i - 1, ctx_pe_din, e.data[31:0]);
        else n_pass++;
        n_total++;
        if ({ctx_rc_en, ctx_im_en, ldm_en} !== 3'b0)
          $display("FAIL b2b_others_idle[%0d]: got %b expected 000",
                   i - 1, {ctx_rc_en, ctx_im_en, ldm_en});
        else n_pass++;
      end
      if (i < 8) begin
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b expected 1", i, cmd_ready);
        else n_pass++;
        e.addr = 32'h0000_0000 | (32'(i) * 32'h27 + 32'h0A);
        e.data = {224'd0, $urandom()};
        cmd_valid = 1'b1; cmd_op = 3'd1; cmd_addr = e.addr; cmd_data = e.data;
        pe_sb.push_back(e);
      end else begin
        cmd_valid = 1'b0;
      end
      @(negedge CLK);
    end
    n_total++;
    if (ctx_pe_en !== 1'b0) $display("FAIL b2b_tail_idle: got %b expected 0", ctx_pe_en);
    else n_pass++;
  endtask

  task automatic test_start_run();
    int n;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_mode = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0; cmd_mode = 1'b0;
    n_total++;
    if ({mode_out, busy, cmd_ready} !== 3'b110)
      $display("FAIL start_status: got %b expected 110", {mode_out, busy, cmd_ready});
    else n_pass++;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      if (!start_out) break;
      n++;
      @(negedge CLK);
    end
    n_total++;
    if (n != TB_START) $display("FAIL start_width: got %0d expected %0d", n, TB_START);
    else n_pass++;
    repeat (47) @(negedge CLK);
    n_total++;
    if ({busy, cmd_ready} !== 2'b10) $display("FAIL run_busy: got %b expected 10",
                                              {busy, cmd_ready});
    else n_pass++;
    complete_in = 1'b1;
    @(negedge CLK);
    complete_in = 1'b0;
    n_total++;
    if ({busy, error, mode_out} !== 3'b001)
      $display("FAIL run_complete: got %b expected 001", {busy, error, mode_out});
    else n_pass++;
  endtask

  task automatic test_readback();
    logic [255:0] e;
    int lat;
    for (int k = 0; k < 2; k++) begin
      logic [31:0] a;
      a = (k == 0) ? 32'h0100_8000 : 32'h0000_7FE0;
      // Second read holds rsp_ready high from the start.
      rsp_ready = (k == 1);
      cmd_valid = 1'b1; cmd_op = 3'd5; cmd_addr = a;
      rd_sb.push_back(ldm_pattern(a[14:5]));
      @(negedge CLK);
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 10) begin
        @(negedge CLK);
        lat++;
      end
      n_total++;
      if (lat != 3) $display("FAIL rd_latency[%0d]: got %0d expected 3", k, lat);
      else n_pass++;
      if (k == 0) begin
        for (int w = 0; w < 5; w++) begin
          n_total++;
          if (rsp_valid !== 1'b1 || rsp_data !== rd_sb[0])
            $display("FAIL rd_hold[%0d]: got v=%b %h expected v=1 %h",
                     w, rsp_valid, rsp_data, rd_sb[0]);
          else n_pass++;
          @(negedge CLK);
        end
        rsp_ready = 1'b1;
      end
      e = rd_sb.pop_front();
      n_total++;
      if (rsp_data !== e) $display("FAIL rd_data[%0d]: got %h expected %h", k, rsp_data, e);
      else n_pass++;
      @(negedge CLK);
      rsp_ready = 1'b0;
      n_total++;
      if ({rsp_valid, busy} !== 2'b00) $display("FAIL rd_done[%0d]: got %b expected 00",
                                                k, {rsp_valid, busy});
      else n_pass++;
    end
  endtask

  task automatic test_timeout();
    int cyc;
    logic early;
    early = 1'b0;
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_mode = 1'b0;
    @(negedge CLK);
    cmd_valid = 1'b0;
    cyc = 1;
    while (busy && cyc < 400) begin
      if (error) early = 1'b1;
      @(negedge CLK);
      cyc++;
    end
    n_total++;
    if (cyc - 1 != TB_START + TB_TIMEOUT)
      $display("FAIL timeout_cycles: got %0d expected %0d", cyc - 1, TB_START + TB_TIMEOUT);
    else n_pass++;
    n_total++;
    if ({error, early, mode_out} !== 3'b100)
      $display("FAIL timeout_error: got %b expected 100", {error, early, mode_out});
    else n_pass++;
    complete_in = 1'b1;
    @(negedge CLK);
    complete_in = 1'b0;
    @(negedge CLK);
    n_total++;
    if ({busy, error, start_out} !== 3'b010)
      $display("FAIL late_complete: got %b expected 010", {busy, error, start_out});
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    cmd_valid = 1'b1; cmd_op = 3'd4; cmd_mode = 1'b1;
    @(negedge CLK);
    cmd_valid = 1'b0;
    repeat (10) @(negedge CLK);
    n_total++;
    if (busy !== 1'b1) $display("FAIL pre_reset_busy: got %b expected 1", busy);
    else n_pass++;
    #2 RST = 1'b0;
    #1;
    n_total++;
    if ({busy, error, start_out, mode_out, rsp_valid} !== 5'b0)
      $display("FAIL midrun_reset_status: got %b expected 00000",
               {busy, error, start_out, mode_out, rsp_valid});
    else n_pass++;
    n_total++;
    if ({ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, ldm_we} !== 5'b0)
      $display("FAIL midrun_reset_enables: got %b expected 00000",
               {ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, ldm_we});
    else n_pass++;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
  endtask

  task automatic test_reserved();
    cmd_valid = 1'b1; cmd_op = 3'd6; cmd_addr = 32'h0000_0013;
    @(negedge CLK);
    cmd_valid = 1'b0;
    n_total++;
    if ({error, busy, cmd_ready} !== 3'b101)
      $display("FAIL reserved_error: got %b expected 101", {error, busy, cmd_ready});
    else n_pass++;
    n_total++;
    if ({ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, start_out} !== 5'b0)
      $display("FAIL reserved_idle: got %b expected 00000",
               {ctx_rc_en, ctx_pe_en, ctx_im_en, ldm_en, start_out});
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_write_remap();
    test_im_write();
    test_back_to_back();
    test_start_run();
    test_readback();
    test_timeout();
    test_reset_mid_run();
    test_reserved();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
